// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit adder cells: the half adder 'an' and the full adder 'fa' built from two of them.
module an (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);
    assign s  = a ^ b;
    assign co = a & b;
endmodule

module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0;
    logic c0;
    logic c1;

    an u_ha0 (.a(a),  .b(b),  .s(s0), .co(c0));
    an u_ha1 (.a(s0), .b(ci), .s(s),  .co(c1));

    assign co = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add cell consumes operand LSBs over WIDTH cycles and
// publishes the WIDTH+1 bit sum on the cycle it enters DONE.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   s
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    // Holds the WIDTH-1 sum bits already produced; the last bit joins it at the final edge.
    logic [WIDTH-2:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   s_q;
    logic             sum_bit;
    logic             carry_out;
    logic             last_bit;

    fa u_fa (
        .a  (opa[0]),
        .b  (opb[0]),
        .ci (carry),
        .s  (sum_bit),
        .co (carry_out)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= (WIDTH-1)'({sum_bit, acc} >> 1);
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= carry_out;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        s_q <= {carry_out, sum_bit, acc};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s = s_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table plus corner-case sequences,
// with a scoreboard queue popped on every done pulse.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W:0]   s;

    int checks;
    int errors;
    int cyc;
    int done_count;
    int done_cyc[$];
    logic [W:0] sb[$];

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W:0]   exp_s;
    } vec_t;

    vec_t vecs[9];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_count++;
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got s=0x%0h, expected no done pulse", s);
            end else begin
                check("sb_result", 32'(s), 32'(sb.pop_front()));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W:0] exp_s);
        int  busy_n;
        bit  seen;
        busy_n = 0;
        seen   = 1'b0;
        @(posedge clk); #1;
        a = va; b = vb; start = 1'b1;
        sb.push_back(exp_s);
        @(posedge clk); #1;
        start = 1'b0;
        a = ~va; b = ~vb;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_cycles", 32'(busy_n), 32'd8);
        @(negedge clk);
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        check("s_hold_idle", 32'(s), 32'(exp_s));
    endtask

    task automatic wait_dones(input int target, input int budget);
        int n;
        n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_budget", 32'(done_count >= target), 32'd1);
    endtask

    initial begin
        int n0;
        int busy_n;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        done_count = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{8'h00, 8'h00, 9'h000};
        vecs[1] = '{8'hFF, 8'h01, 9'h100};
        vecs[2] = '{8'hFF, 8'hFF, 9'h1FE};
        vecs[3] = '{8'h5A, 8'h3C, 9'h096};
        vecs[4] = '{8'hAA, 8'h55, 9'h0FF};
        vecs[5] = '{8'h7F, 8'h01, 9'h080};
        vecs[6] = '{8'h01, 8'h01, 9'h002};
        vecs[7] = '{8'h80, 8'h80, 9'h100};
        vecs[8] = '{8'hC3, 8'h5E, 9'h121};

        repeat (3) @(posedge clk);
        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_s", 32'(s), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].exp_s);
        end

        // start pulsed and operands changed while an addition is in flight
        n0 = done_count;
        @(posedge clk); #1;
        a = 8'h0F; b = 8'h01; start = 1'b1;
        sb.push_back(9'h010);
        @(posedge clk); #1;
        start = 1'b0; a = 8'hAA; b = 8'h55;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'h33; b = 8'hCC;
        wait_dones(n0 + 1, 30);
        repeat (12) @(negedge clk);
        check("single_done", 32'(done_count - n0), 32'd1);
        check("s_after_ignored_start", 32'(s), 32'h010);

        // asynchronous reset in the 4th RUN cycle
        @(posedge clk); #1;
        a = 8'h80; b = 8'h80; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 20 && busy_n < 4; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
        end
        check("reach_run4", 32'(busy_n), 32'd4);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_s", 32'(s), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {30'd0, busy, done}, 32'd0);
        run_op(8'h80, 8'h80, 9'h100);

        // start held high: three back-to-back operations
        n0 = done_count;
        @(posedge clk); #1;
        a = 8'h12; b = 8'h34; start = 1'b1;
        repeat (3) sb.push_back(9'h046);
        wait_dones(n0 + 2, 40);
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        wait_dones(n0 + 3, 30);
        repeat (14) @(negedge clk);
        check("b2b_done_count", 32'(done_count - n0), 32'd3);
        if (done_cyc.size() >= n0 + 3) begin
            check("b2b_spacing_1", 32'(done_cyc[n0 + 1] - done_cyc[n0]), 32'd10);
            check("b2b_spacing_2", 32'(done_cyc[n0 + 2] - done_cyc[n0 + 1]), 32'd10);
        end else begin
            check("b2b_spacing_avail", 32'(done_cyc.size()), 32'(n0 + 3));
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
